// File: rtl/fc_layer_seq.sv
// fc_layer_seq: sequential fully connected layer with one time-shared MAC.
// Streams in an N_IN-element signed vector and computes N_OUT dot products
// against on-chip weight/bias memories. Each result gets its bias added, is
// arithmetically shifted right by SHIFT and saturated to DW bits, and is then
// streamed out.
// Optional build macro FC_RELU_EN: negative saturated results are clamped to 0.
module fc_layer_seq #(
  parameter int N_IN  = 16,
  parameter int N_OUT = 8,
  parameter int DW    = 8,
  parameter int WW    = 8,
  parameter int BW    = 16,
  parameter int ACC_W = 32,
  parameter int SHIFT = 8,
  localparam int WAW  = $clog2(N_OUT * N_IN),
  localparam int BAW  = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           w_we,
  input  logic [WAW-1:0] w_addr,
  input  logic [WW-1:0]  w_data,
  input  logic           b_we,
  input  logic [BAW-1:0] b_addr,
  input  logic [BW-1:0]  b_data,
  output logic           busy,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [DW-1:0]  in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [DW-1:0]  out_data,
  output logic           out_last
);

  localparam int IW    = $clog2(N_IN);
  localparam int OW    = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int PW    = DW + WW;
  localparam int DEPTH = N_OUT * N_IN;

  // Saturation bounds of a DW-bit signed value, held at accumulator width.
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [2:0] {IDLE, LOAD, MAC, FINISH, EMIT} state_t;

  state_t                  state;
  logic [IW-1:0]           idx_i;
  logic [OW-1:0]           idx_o;
  logic signed [DW-1:0]    x_buf [N_IN];
  logic signed [WW-1:0]    w_mem [DEPTH];
  logic signed [BW-1:0]    b_mem [N_OUT];
  logic signed [ACC_W-1:0] acc;
  logic [WAW-1:0]          w_idx;
  logic signed [PW-1:0]    prod;
  logic signed [ACC_W-1:0] acc_next;
  logic signed [ACC_W-1:0] res_full;
  logic signed [DW-1:0]    res;
  logic                    in_hs;

  // Sign-extend a full-precision product to accumulator width.
  function automatic logic signed [ACC_W-1:0] sext_prod(input logic signed [PW-1:0] p);
    return ACC_W'(p);
  endfunction

  // Sign-extend a bias word to accumulator width.
  function automatic logic signed [ACC_W-1:0] sext_bias(input logic signed [BW-1:0] b);
    return ACC_W'(b);
  endfunction

  // Clamp a shifted accumulator value into the DW-bit signed range.
  function automatic logic signed [DW-1:0] sat(input logic signed [ACC_W-1:0] v);
    if (v > SAT_MAX) return DW'(SAT_MAX);
    if (v < SAT_MIN) return DW'(SAT_MIN);
    return DW'(v);
  endfunction

  // Optional rectification of the saturated result.
  function automatic logic signed [DW-1:0] relu(input logic signed [DW-1:0] v);
`ifdef FC_RELU_EN
    return v[DW-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  assign busy     = (state != IDLE);
  assign in_hs    = in_valid && in_ready;
  assign w_idx    = WAW'(int'(idx_o) * N_IN + int'(idx_i));
  assign prod     = PW'(x_buf[idx_i]) * PW'(w_mem[w_idx]);
  // The first term of each dot product starts from zero rather than the old sum.
  assign acc_next = ((idx_i == '0) ? '0 : acc) + sext_prod(prod);
  assign res_full = (acc + sext_bias(b_mem[idx_o])) >>> SHIFT;
  assign res      = relu(sat(res_full));

  // Configuration writes land only while idle so a running vector sees stable coefficients.
  always_ff @(posedge clk) begin
    if (w_we && state == IDLE) w_mem[w_addr] <= w_data;
    if (b_we && state == IDLE) b_mem[b_addr] <= b_data;
  end

  // Input capture and the multiply-accumulate, one term per MAC cycle.
  always_ff @(posedge clk) begin
    if (in_hs) x_buf[idx_i] <= in_data;
    if (state == MAC) acc <= acc_next;
  end

  // Control FSM sequencing load, per-output MAC, finish and emit with registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx_i     <= '0;
      idx_o     <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_hs) begin
            idx_i <= IW'(1);
            state <= LOAD;
          end
        end
        LOAD: begin
          if (in_hs) begin
            if (idx_i == IW'(N_IN - 1)) begin
              idx_i    <= '0;
              idx_o    <= '0;
              in_ready <= 1'b0;
              state    <= MAC;
            end else begin
              idx_i <= idx_i + IW'(1);
            end
          end
        end
        MAC: begin
          if (idx_i == IW'(N_IN - 1)) begin
            idx_i <= '0;
            state <= FINISH;
          end else begin
            idx_i <= idx_i + IW'(1);
          end
        end
        FINISH: begin
          out_data  <= res;
          out_valid <= 1'b1;
          out_last  <= (idx_o == OW'(N_OUT - 1));
          state     <= EMIT;
        end
        EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (idx_o == OW'(N_OUT - 1)) begin
              idx_o    <= '0;
              in_ready <= 1'b1;
              state    <= IDLE;
            end else begin
              idx_o <= idx_o + OW'(1);
              state <= MAC;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/fc_layer_seq.md
Name: fc_layer_seq

Overview:
Sequential, parametrised fully connected layer for the YOLO inference datapath.
- Streams in an N_IN-element signed activation vector over a valid/ready handshake.
- Computes N_OUT dot products with one time-shared MAC against on-chip weight and bias memories, then adds bias, right-shifts and saturates each result.
- Streams N_OUT signed results out over a valid/ready handshake, so it can replace the fully parallel single-cycle layer where area matters.

Parameters:
N_IN, 16, input vector length (>=2)
N_OUT, 8, output vector length (>=1)
DW, 8, activation/output width, signed
WW, 8, weight width, signed
BW, 16, bias width, signed
ACC_W, 32, accumulator width (>= DW+WW+clog2(N_IN))
SHIFT, 8, arithmetic right shift applied before saturation (0..ACC_W-1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
w_we  in  1  weight write strobe
w_addr  in  clog2(N_OUT*N_IN)  weight address = o*N_IN + i
w_data  in  WW  weight value W[o][i]
b_we  in  1  bias write strobe
b_addr  in  clog2(N_OUT)  bias index
b_data  in  BW  bias value
busy  out  1  high in any state other than IDLE
in_valid  in  1  input element valid
in_ready  out  1  block accepts input element
in_data  in  DW  input element x[i], sent i=0 first
out_valid  out  1  output element valid
out_ready  in  1  downstream accepts output
out_data  out  DW  output element y[o], sent o=0 first
out_last  out  1  high with y[N_OUT-1]

Behaviour:
- Reset is asynchronous, active-low (rst_n), on clock clk. Reset values: busy=0, in_ready=0, out_valid=0, out_data=0, out_last=0; state=IDLE; counters=0. Weight/bias memories are not cleared.
- Reset mid-operation aborts the vector. No partial output is emitted after reset.
- FSM states: IDLE -> LOAD -> MAC -> FINISH -> EMIT -> (MAC for next o | IDLE).
- IDLE: in_ready=1. The first in_valid&&in_ready handshake stores x[0] and moves to LOAD.
- IDLE config writes: w_we/b_we are honoured only in IDLE. Writes in any other state are ignored.
- LOAD: in_ready=1. Each handshake stores x[i] into the buffer. On the handshake with i=N_IN-1, go to MAC with o=0.
- MAC: in_ready=0. One cycle per i=0..N_IN-1: acc <= (i==0 ? 0 : acc) + sext(x[i]*W[o][i]). After i=N_IN-1, go to FINISH.
- FINISH (1 cycle): t = (acc + sext(b[o])) >>> SHIFT, then saturate to [-2^(DW-1), 2^(DW-1)-1]. Register the result into out_data and set out_valid=1, out_last=(o==N_OUT-1). Go to EMIT.
- EMIT: out_data and out_last are held stable while out_valid && !out_ready. On handshake:
  - out_valid drops the next cycle unless a new result is registered.
  - If o<N_OUT-1: o++, go to MAC.
  - Else go to IDLE.
- Latency: the first out_valid rises N_IN+1 rising edges after the edge accepting x[N_IN-1]. Each later output follows N_IN+1 cycles after the previous output handshake.
- Arithmetic: all operands are two's complement. Accumulator overflow wraps modulo 2^ACC_W; no detection.
- in_ready is 0 in MAC/FINISH/EMIT. A new vector can start only after the last output handshake.

Optional Feature:
FC_RELU_EN
- Defined: a saturated result <0 is replaced by 0 before registering, so out_data is in [0, 2^(DW-1)-1].
- Undefined: signed saturated result passes unchanged.
- Timing is identical in both cases.

Test Plan:
1. Basic dot product (N_IN=4, N_OUT=2, SHIFT=0). W0=[1,1,1,1], b0=10; W1=[-1,-2,-3,-4], b1=0; x=[1,2,3,4] -> y0=20, then y1=-30 with out_last=1. First out_valid on the 5th edge after x[3] accepted.
2. Saturation and shift (SHIFT=0). x=[100,100,100,100], W0=[127,127,127,127], b0=0 -> y0=127. With W0 negated -> y0=-128. With SHIFT=8, b0=256 -> (50800+256)>>>8=199 -> 127.
3. Backpressure: hold out_ready=0 for 5 cycles during y0 -> out_valid stays 1, out_data stays 20, no MAC progress. Release -> y1=-30 follows N_IN+1 cycles later.
4. Config gating: w_we to W0[0]=50 while busy=1 -> ignored, result unchanged (20). Same write in IDLE -> the next vector gives y0=69.
5. Reset mid-MAC: assert rst_n=0 during o=1 MAC -> out_valid=0, busy=0, in_ready=0 during reset. After release, in_ready=1, and a fresh vector reproduces test 1's results (weights retained).
6. FC_RELU_EN defined: test 1 stimulus -> y0=20, y1=0.
